// File: rtl/output_wrapper_par_if.sv
// Producer/consumer bundle for output_wrapper_par: word capture on one side,
// chunked two-phase handshake plus status on the other.
interface output_wrapper_par_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
);
  logic             done;
  logic [IN_W-1:0]  in_data;
  logic             msb_first;
  logic             got_data;
  logic             flush;
  logic [OUT_W-1:0] out_bus;
  logic             ready_for_input;
  logic             buffer_ready;
  logic             last_chunk;
  logic             busy;
  logic [CNT_W-1:0] word_count;

  modport master (
    input  done, in_data, msb_first, got_data, flush,
    output out_bus, ready_for_input, buffer_ready, last_chunk, busy, word_count
  );

  modport slave (
    output done, in_data, msb_first, got_data, flush,
    input  out_bus, ready_for_input, buffer_ready, last_chunk, busy, word_count
  );
endinterface

// File: rtl/output_wrapper_par.sv
// Serialises a captured IN_W word into IN_W/OUT_W chunks over a level-based
// two-phase got_data handshake, counting fully delivered words.
module output_wrapper_par #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  output_wrapper_par_if.master bus
);
  localparam int N     = IN_W / OUT_W;
  localparam int IDX_W = $clog2(N + 1);
  localparam int KW    = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N);

  typedef enum logic [2:0] {IDLE, EMPTY, SHIFT, WAIT_GOT, RELEASE} state_t;

  state_t                    state_q, state_d;
  logic [N-1:0][OUT_W-1:0]   buf_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      order_q;
  logic [OUT_W-1:0]          out_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [KW-1:0]             k;
  logic                      cap, ld, inc;

  // Chunk position inside the word; idx never exceeds N-1 while in SHIFT.
  always_comb begin
    if (order_q) k = KW'(IDX_LAST - IDX_W'(1) - idx_q);
    else         k = KW'(idx_q);
  end

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    ld      = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE:     if (!bus.done) state_d = EMPTY;
      EMPTY:    if (bus.done) begin state_d = SHIFT; cap = 1'b1; end
      SHIFT:    begin state_d = WAIT_GOT; ld = 1'b1; end
      WAIT_GOT: if (bus.got_data) state_d = RELEASE;
      RELEASE:  if (!bus.got_data) begin
                  if (idx_q < IDX_LAST) state_d = SHIFT;
                  else begin state_d = IDLE; inc = 1'b1; end
                end
      default:  state_d = IDLE;
    endcase
    // flush wins over every transition and suppresses all datapath updates
    if (bus.flush) begin
      state_d = IDLE;
      cap     = 1'b0;
      ld      = 1'b0;
      inc     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      order_q <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        buf_q <= '0;
        idx_q <= '0;
      end
      if (cap) begin
        buf_q   <= bus.in_data;
        order_q <= bus.msb_first;
        idx_q   <= '0;
      end
      if (ld) begin
        out_q <= buf_q[k];
        idx_q <= idx_q + 1'b1;
      end
      if (inc) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.out_bus         = out_q;
  assign bus.word_count      = cnt_q;
  assign bus.ready_for_input = (state_q == EMPTY);
  assign bus.buffer_ready    = (state_q == WAIT_GOT);
  assign bus.last_chunk      = (state_q == WAIT_GOT) && (idx_q == IDX_LAST);
  assign bus.busy            = (state_q == SHIFT) || (state_q == WAIT_GOT) ||
                               (state_q == RELEASE);
endmodule
